// File: rtl/msp430_clk_en_sequencer.sv
// ----------------------------------------------------------------------------
// msp430_clk_en_sequencer
//
// Produces the enable for msp430_clock_gate for one gated clock domain:
//   - divides the domain rate by 1/2/4/8 (gate_en pulses on the divided tick),
//   - drains outstanding activity before stopping the domain on an off request,
//   - sequences wake-up with a one-cycle acknowledge.
//
// Parameters
//   SETTLE_CYC  consecutive idle (busy=0) cycles required in DRAIN before
//               gating off; legal values are >= 1
//
// Ports
//   mclk      in   free-running clock
//   puc_rst   in   asynchronous active-high reset
//   div_sel   in   [1:0] rate select: 0=/1, 1=/2, 2=/4, 3=/8
//   off_req   in   level request to stop the domain clock
//   busy      in   domain activity pending; gating off forbidden while high
//   wkup      in   wake-up request (level)
//   gate_en   out  enable to the clock gate (registered)
//   clk_off   out  high while the domain clock is stopped (registered)
//   wkup_ack  out  single-cycle pulse on wake-up (registered)
//
// Configuration
//   MSP430_CLKEN_WKUP_SYNC_EN  when defined, wkup passes through a 2-flop
//                              synchronizer before the FSM (adds 2 cycles of
//                              wake latency); when undefined wkup must be
//                              synchronous to mclk.
// ----------------------------------------------------------------------------
module msp430_clk_en_sequencer #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       mclk,
  input  logic       puc_rst,
  input  logic [1:0] div_sel,
  input  logic       off_req,
  input  logic       busy,
  input  logic       wkup,
  output logic       gate_en,
  output logic       clk_off,
  output logic       wkup_ack
);

  localparam int unsigned DIV_W    = 3;
  localparam int unsigned SETTLE_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    div_mask;
  logic                div_tick;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W-1:0] settle_nxt;
  logic                wkup_int;

  // Wake request source: optionally resynchronized into mclk
`ifdef MSP430_CLKEN_WKUP_SYNC_EN
  logic [1:0] wkup_sync;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      wkup_sync <= 2'b00;
    end else begin
      wkup_sync <= {wkup_sync[0], wkup};
    end
  end

  assign wkup_int = wkup_sync[1];
`else
  assign wkup_int = wkup;
`endif

  // Divider tick: all low bits selected by div_sel are set
  assign div_mask = DIV_W'((4'd1 << div_sel) - 4'd1);
  assign div_tick = ((div_cnt & div_mask) == div_mask);

  // Next-state and settle counter; wkup takes priority over off_req everywhere
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      ST_RUN: begin
        if (off_req && !wkup_int) begin
          state_nxt  = ST_DRAIN;
          settle_nxt = SETTLE_W'(SETTLE_CYC);
        end
      end
      ST_DRAIN: begin
        if (!off_req || wkup_int) begin
          state_nxt = ST_RUN;
        end else if (busy) begin
          settle_nxt = SETTLE_W'(SETTLE_CYC);
        end else begin
          settle_nxt = settle_cnt - SETTLE_W'(1);
          if (settle_cnt == SETTLE_W'(1)) begin
            state_nxt = ST_OFF;
          end
        end
      end
      ST_OFF: begin
        if (wkup_int || !off_req) begin
          state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // State, divider and outputs; outputs follow the state being entered
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state      <= ST_RUN;
      settle_cnt <= '0;
      div_cnt    <= '0;
      gate_en    <= 1'b0;
      clk_off    <= 1'b0;
      wkup_ack   <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      wkup_ack   <= 1'b0;
      case (state_nxt)
        ST_RUN, ST_DRAIN: begin
          gate_en <= div_tick;
          clk_off <= 1'b0;
          div_cnt <= div_cnt + DIV_W'(1);
        end
        ST_OFF: begin
          // divider frozen while the domain is stopped
          gate_en <= 1'b0;
          clk_off <= 1'b1;
        end
        ST_WAKE: begin
          gate_en  <= 1'b1;
          clk_off  <= 1'b0;
          wkup_ack <= 1'b1;
          div_cnt  <= '0;
        end
        default: begin
          gate_en <= 1'b0;
          clk_off <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msp430_clk_en_sequencer.sv
// ----------------------------------------------------------------------------
// Testbench for msp430_clk_en_sequencer (default build, wkup unsynchronized).
// Expected {gate_en, clk_off, wkup_ack} triples come from a cycle model and
// pass through a scoreboard queue; directed steps add hand-derived checks.
// ----------------------------------------------------------------------------
module tb_msp430_clk_en_sequencer;

  localparam int SETTLE = 4;

  logic       mclk = 1'b0;
  logic       puc_rst;
  logic [1:0] div_sel;
  logic       off_req;
  logic       busy;
  logic       wkup;
  logic       gate_en;
  logic       clk_off;
  logic       wkup_ack;

  int n_assert = 0;
  int n_fail   = 0;

  // scoreboard of expected {gate_en, clk_off, wkup_ack}
  logic [2:0] sb_q[$];

  // cycle model: 0=RUN 1=DRAIN 2=OFF 3=WAKE
  int m_st  = 0;
  int m_cnt = 0;
  int m_set = 0;

  msp430_clk_en_sequencer #(.SETTLE_CYC(SETTLE)) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .div_sel  (div_sel),
    .off_req  (off_req),
    .busy     (busy),
    .wkup     (wkup),
    .gate_en  (gate_en),
    .clk_off  (clk_off),
    .wkup_ack (wkup_ack)
  );

  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] cur();
    return {gate_en, clk_off, wkup_ack};
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic [1:0] d, input logic o, input logic b,
                      input logic w, input string tag);
    int         ns;
    int         nset;
    int         period;
    bit         tick;
    logic [2:0] e;
    div_sel = d;
    off_req = o;
    busy    = b;
    wkup    = w;
    period  = 1 << d;
    tick    = ((m_cnt % period) == (period - 1));
    ns      = m_st;
    nset    = m_set;
    case (m_st)
      0: if (o && !w) begin ns = 1; nset = SETTLE; end
      1: begin
        if (!o || w) ns = 0;
        else if (b) nset = SETTLE;
        else begin
          if (m_set == 1) ns = 2;
          nset = m_set - 1;
        end
      end
      2: if (w || !o) ns = 3;
      default: ns = 0;
    endcase
    case (ns)
      0, 1: begin e = {tick, 2'b00}; m_cnt = (m_cnt + 1) % 8; end
      2:    e = 3'b010;
      default: begin e = 3'b101; m_cnt = 0; end
    endcase
    m_st  = ns;
    m_set = nset;
    sb_q.push_back(e);
    @(posedge mclk);
    #1;
    e = sb_q.pop_front();
    chk(tag, cur(), e);
  endtask

  // Asynchronous reset: outputs must clear without a clock edge
  task automatic do_reset();
    div_sel = 2'd0;
    off_req = 1'b0;
    busy    = 1'b0;
    wkup    = 1'b0;
    puc_rst = 1'b1;
    #1;
    chk("reset_async", cur(), 3'b000);
    @(posedge mclk);
    #1;
    chk("reset_hold", cur(), 3'b000);
    puc_rst = 1'b0;
    m_st  = 0;
    m_cnt = 0;
    m_set = 0;
  endtask

  initial begin
    do_reset();

    // /1: gate_en continuously high
    for (int k = 1; k <= 3; k++) begin
      step(2'd0, 1'b0, 1'b0, 1'b0, "div1");
      chk("div1_direct", cur(), 3'b100);
    end

    // /4 from reset: high on edges 4, 8, 12; switch to /2 at edge 13
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      step((k >= 13) ? 2'd1 : 2'd2, 1'b0, 1'b0, 1'b0, "div4");
      chk("div4_edge", cur(), {(k == 4 || k == 8 || k == 12 || k == 14), 2'b00});
    end

    // off request with no busy: four DRAIN cycles then OFF
    step(2'd1, 1'b1, 1'b0, 1'b0, "enter_drain");
    for (int i = 1; i <= SETTLE; i++) begin
      step(2'd1, 1'b1, 1'b0, 1'b0, "drain");
      chk("drain_clk_off", {2'b00, clk_off}, {2'b00, (i == SETTLE)});
    end
    chk("off_outputs", cur(), 3'b010);

    // stay OFF, then one-cycle wkup pulse
    step(2'd1, 1'b1, 1'b0, 1'b0, "off_hold");
    chk("off_hold_direct", cur(), 3'b010);
    step(2'd1, 1'b1, 1'b0, 1'b1, "wake");
    chk("wake_direct", cur(), 3'b101);
    step(2'd1, 1'b1, 1'b0, 1'b0, "first_run");
    chk("first_run_direct", cur(), 3'b000);

    // busy pulse in DRAIN cycle 3 delays OFF to 4 cycles after busy falls
    step(2'd1, 1'b1, 1'b0, 1'b0, "enter_drain2");
    step(2'd1, 1'b1, 1'b0, 1'b0, "drain2_c1");
    step(2'd1, 1'b1, 1'b0, 1'b0, "drain2_c2");
    step(2'd1, 1'b1, 1'b1, 1'b0, "drain2_busy");
    for (int i = 1; i <= 4; i++) begin
      step(2'd1, 1'b1, 1'b0, 1'b0, "drain2_idle");
      chk("drain2_clk_off", {2'b00, clk_off}, {2'b00, (i == 4)});
    end

    // dropping off_req in OFF also wakes
    step(2'd1, 1'b0, 1'b0, 1'b0, "wake_offreq");
    chk("wake_offreq_direct", cur(), 3'b101);
    step(2'd1, 1'b0, 1'b0, 1'b0, "run_after_wake");

    // busy and wkup together in DRAIN abandon the drain
    step(2'd1, 1'b1, 1'b0, 1'b0, "enter_drain3");
    step(2'd1, 1'b1, 1'b1, 1'b1, "drain_abort");
    chk("drain_abort_direct", {1'b0, clk_off, wkup_ack}, 3'b000);

    // off_req with wkup held in RUN: never leaves RUN
    for (int k = 1; k <= 5; k++) begin
      step(2'd1, 1'b1, 1'b0, 1'b1, "wkup_override");
      chk("wkup_override_direct", {1'b0, clk_off, wkup_ack}, 3'b000);
    end

    // reach OFF, then reset mid-cycle
    for (int k = 0; k <= SETTLE; k++) begin
      step(2'd2, 1'b1, 1'b0, 1'b0, "to_off");
    end
    chk("to_off_direct", cur(), 3'b010);
    do_reset();

    // /8 from reset: high on edges 8 and 16 across the counter wrap
    for (int k = 1; k <= 16; k++) begin
      step(2'd3, 1'b0, 1'b0, 1'b0, "div8");
      chk("div8_edge", cur(), {(k % 8 == 0), 2'b00});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
